timer_unit: RTL
===============

TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 Parameters (name, default, meaning): NUM_CH, 4, number of timer channels (1..8); CNT_BITS, 32, counter/load width (8..32); DBITS, 32, bus data/address width; BASE_ADDR, 32'hF0000020, base of register window.
REQ-002 Ports (name  direction  width  meaning): clk  in  1  sole clock, all state on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 addrIn  in  DBITS  byte address from memory stage.
REQ-005 wrtEn  in  1  store strobe, one cycle per write.
REQ-006 rdEn  in  1  load strobe, one cycle per read.
REQ-007 dataIn  in  DBITS  store data.
REQ-008 dataOut  out  DBITS  load data, registered.
REQ-009 tick  out  NUM_CH  one-cycle expiry pulse per channel.
REQ-010 clkOut  out  NUM_CH  per-channel square wave (toggle mode).
REQ-011 irq  out  1  registered OR of (expired & irqEn) over channels.

Function
REQ-012 Register map, channel c at BASE_ADDR + 16*c: +0 CTRL (bit0 en, bits2:1 mode 00 one-shot/01 periodic/10 toggle/11 reserved=periodic, bit3 irqEn); +4 LOAD; +8 COUNT read-only; +C STATUS bit0 expired, write-1-to-clear.
REQ-013 Global PRESCALE register at BASE_ADDR + 16*NUM_CH (see REQ-027).
REQ-014 Address decode uses addrIn[DBITS-1:2]; bits 1:0 ignored; addresses outside window: writes ignored, reads return 0.
REQ-015 Read latency exactly 1 cycle: dataOut valid the cycle after rdEn, holds until next rdEn; unused high bits read 0.
REQ-016 Writes take effect on the clk edge where wrtEn is high; CNT_BITS above width are discarded.
REQ-017 Channel advances on each step cycle (every cycle, or prescaler terminal cycle per REQ-027) while en=1: if COUNT >= LOAD then event, else COUNT <= COUNT+1.
REQ-018 Event: COUNT <= 0, tick[c] high for exactly one clk cycle, expired set; period = LOAD+1 steps.
REQ-019 One-shot: event also clears en; periodic: continues; toggle: clkOut[c] inverts, square wave period 2*(LOAD+1) steps.
REQ-020 CTRL write with en 0->1 clears COUNT to 0 that cycle (no step that cycle); en 1->1 rewrite keeps COUNT; en=0 freezes COUNT and clkOut.
REQ-021 LOAD rewrite while running applies to next compare; COUNT > new LOAD fires event on next step (no wrap through 2^CNT_BITS).
REQ-022 LOAD=0 while enabled: event every step.
REQ-023 Simultaneous event and STATUS write-1 clear on same channel: set wins, expired stays 1.
REQ-024 Writes to COUNT ignored; STATUS write-0 bits no effect.
REQ-025 irq registered: asserts 1 cycle after expired&irqEn becomes true, deasserts 1 cycle after clear.

Reset
REQ-026 reset low asynchronously forces: all CTRL/LOAD/COUNT/STATUS 0, PRESCALE 0, prescale counter 0, dataOut 0, tick 0, clkOut 0, irq 0; release synchronous to clk for first step.

Configuration
REQ-027 Macro TIMER_PRESCALE_EN defined: 16-bit shared prescaler, step cycle when prescale counter == PRESCALE then counter <= 0, else +1 (step every PRESCALE+1 cycles); PRESCALE readable/writable; write resets prescale counter.
REQ-028 TIMER_PRESCALE_EN undefined: every cycle is a step cycle; PRESCALE address reads 0, writes ignored; no prescaler flops.

Verification
REQ-029 LOAD0=3, CTRL0=0x3 (en, periodic) -> tick[0] every 4 cycles, COUNT reads 0,1,2,3 cycling, expired=1.
REQ-030 LOAD1=9, CTRL1=0x1 (one-shot) -> single tick[1] 10 cycles after write, CTRL1 reads 0x0, COUNT1 stays 0.
REQ-031 LOAD2=4, CTRL2=0x5 (toggle) -> clkOut[2] period 10 cycles, 50% duty.
REQ-032 CTRL0=0x9, LOAD0=2, wait expiry -> irq=1 one cycle after expired; STATUS write 1 on event cycle -> expired remains 1; later clear -> irq=0 next cycle.
REQ-033 COUNT0=7 running, write LOAD0=2 -> event on next step, COUNT0=0; read 0xF0000100 -> dataOut=0.
REQ-034 With TIMER_PRESCALE_EN, PRESCALE=4, LOAD0=1, periodic -> tick[0] every 10 cycles; reset low mid-count -> all outputs 0 immediately, no clk edge needed.

Source files
------------

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped multi-channel timer block.
// Each channel has CTRL / LOAD / COUNT / STATUS registers at a 16-byte
// stride above BASE_ADDR; a global PRESCALE register follows the last
// channel. Channels count up to LOAD, then fire a one-cycle tick, set the
// expired flag and either stop (one-shot), continue (periodic) or toggle
// their clkOut line (toggle).
// Build option: define TIMER_PRESCALE_EN to add a shared 16-bit prescaler.
// Without it every cycle is a step cycle, PRESCALE reads 0 and writes to it
// are ignored.
module timer_unit #(
   parameter int               NUM_CH    = 4,
   parameter int               CNT_BITS  = 32,
   parameter int               DBITS     = 32,
   parameter logic [DBITS-1:0] BASE_ADDR = 32'hF0000020
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DBITS-1:0]  addrIn,
   input  logic              wrtEn,
   input  logic              rdEn,
   input  logic [DBITS-1:0]  dataIn,
   output logic [DBITS-1:0]  dataOut,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clkOut,
   output logic              irq
);

   // Word-address arithmetic: byte lanes (addrIn[1:0]) never take part.
   localparam int WW  = DBITS - 2;
   localparam int CSW = WW - 2;

   localparam logic [WW-1:0] BASE_WORD = BASE_ADDR[DBITS-1:2];
   localparam logic [WW-1:0] LAST_OFF  = WW'(4 * NUM_CH);

   // Register selector within a channel block
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   // Channel modes (2'b11 behaves as periodic)
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_TOGGLE  = 2'b10;

   // ------------------------------------------------------------------
   // Channel state
   // ------------------------------------------------------------------
   logic [NUM_CH-1:0]   r_en;
   logic [NUM_CH-1:0]   r_irqen;
   logic [1:0]          r_mode  [NUM_CH];
   logic [CNT_BITS-1:0] r_load  [NUM_CH];
   logic [CNT_BITS-1:0] r_count [NUM_CH];
   logic [NUM_CH-1:0]   r_expired;
   logic [NUM_CH-1:0]   r_tick;
   logic [NUM_CH-1:0]   r_clkout;
   logic                r_irq;
   logic [DBITS-1:0]    r_dout;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   logic [WW-1:0]     w_word;
   logic [WW-1:0]     w_off;
   logic              w_hit;
   logic              w_pre_sel;
   logic [CSW-1:0]    w_chsel;
   logic [1:0]        w_reg;
   logic [NUM_CH-1:0] w_sel;
   logic [NUM_CH-1:0] w_ctrl_wr;
   logic [NUM_CH-1:0] w_load_wr;
   logic [NUM_CH-1:0] w_stat_wr;
   logic [NUM_CH-1:0] w_start;
   logic [NUM_CH-1:0] w_run;
   logic              w_step;
   logic [DBITS-1:0]  w_rdata;

   assign w_word    = addrIn[DBITS-1:2];
   assign w_off     = w_word - BASE_WORD;
   assign w_hit     = (w_word >= BASE_WORD) && (w_off <= LAST_OFF);
   assign w_pre_sel = w_hit && (w_off == LAST_OFF);
   assign w_chsel   = w_off[WW-1:2];
   assign w_reg     = w_off[1:0];

   // Per-channel select, write strobes and run/start qualification.
   // A CTRL write that keeps en=1 lets the channel step that cycle; an
   // en 0->1 write restarts COUNT at 0 instead of stepping.
   always_comb begin
      w_sel     = '0;
      w_ctrl_wr = '0;
      w_load_wr = '0;
      w_stat_wr = '0;
      w_start   = '0;
      w_run     = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         w_sel[c]     = w_hit && (w_chsel == CSW'(c));
         w_ctrl_wr[c] = wrtEn && w_sel[c] && (w_reg == REG_CTRL);
         w_load_wr[c] = wrtEn && w_sel[c] && (w_reg == REG_LOAD);
         w_stat_wr[c] = wrtEn && w_sel[c] && (w_reg == REG_STATUS);
         w_start[c]   = w_ctrl_wr[c] && dataIn[0] && !r_en[c];
         w_run[c]     = r_en[c] && (!w_ctrl_wr[c] || dataIn[0]);
      end
   end

   // ------------------------------------------------------------------
   // Optional shared prescaler
   // ------------------------------------------------------------------
`ifdef TIMER_PRESCALE_EN
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;
   logic        w_pre_wr;
   logic        w_unused_bits;

   assign w_pre_wr      = wrtEn && w_pre_sel;
   assign w_step        = (r_pcnt == r_prescale);
   assign w_unused_bits = ^{addrIn[1:0], dataIn};

   // Prescale register and free-running step counter; a PRESCALE write
   // realigns the counter so the new ratio starts cleanly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prescale <= '0;
         r_pcnt     <= '0;
      end else if (w_pre_wr) begin
         r_prescale <= dataIn[15:0];
         r_pcnt     <= '0;
      end else if (w_step) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + 16'd1;
      end
   end
`else
   logic w_unused_bits;

   assign w_step        = 1'b1;
   assign w_unused_bits = ^{addrIn[1:0], dataIn, w_pre_sel};
`endif

   // ------------------------------------------------------------------
   // Read mux (combinational; registered into dataOut below)
   // ------------------------------------------------------------------
   // Selects the addressed register, zero-extended; unmapped reads give 0.
   always_comb begin
      w_rdata = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (w_sel[c]) begin
            case (w_reg)
               REG_CTRL:   w_rdata[3:0] = {r_irqen[c], r_mode[c], r_en[c]};
               REG_LOAD:   w_rdata[CNT_BITS-1:0] = r_load[c];
               REG_COUNT:  w_rdata[CNT_BITS-1:0] = r_count[c];
               default:    w_rdata[0] = r_expired[c];
            endcase
         end
      end
`ifdef TIMER_PRESCALE_EN
      if (w_pre_sel) begin
         w_rdata[15:0] = r_prescale;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Channel counters, control and status
   // ------------------------------------------------------------------
   // Statement order matters: the event path follows the CTRL write (so a
   // one-shot expiry clears en) and the STATUS clear (so a set wins).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_en      <= '0;
         r_irqen   <= '0;
         r_expired <= '0;
         r_tick    <= '0;
         r_clkout  <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            r_mode[c]  <= '0;
            r_load[c]  <= '0;
            r_count[c] <= '0;
         end
      end else begin
         r_tick <= '0;
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (w_ctrl_wr[c]) begin
               r_en[c]    <= dataIn[0];
               r_mode[c]  <= dataIn[2:1];
               r_irqen[c] <= dataIn[3];
            end
            if (w_load_wr[c]) begin
               r_load[c] <= dataIn[CNT_BITS-1:0];
            end
            if (w_stat_wr[c] && dataIn[0]) begin
               r_expired[c] <= 1'b0;
            end
            if (w_start[c]) begin
               r_count[c] <= '0;
            end else if (w_run[c] && w_step) begin
               // >= rather than == so a LOAD lowered below COUNT fires at
               // once instead of wrapping through the full counter range.
               if (r_count[c] >= r_load[c]) begin
                  r_count[c]   <= '0;
                  r_tick[c]    <= 1'b1;
                  r_expired[c] <= 1'b1;
                  if (r_mode[c] == MODE_ONESHOT) begin
                     r_en[c] <= 1'b0;
                  end
                  if (r_mode[c] == MODE_TOGGLE) begin
                     r_clkout[c] <= ~r_clkout[c];
                  end
               end else begin
                  r_count[c] <= r_count[c] + 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Interrupt and read data registers
   // ------------------------------------------------------------------
   // Interrupt follows the expired flags one cycle later.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_expired & r_irqen);
      end
   end

   // Load data captured on rdEn and held until the next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dout <= '0;
      end else if (rdEn) begin
         r_dout <= w_rdata;
      end
   end

   assign dataOut = r_dout;
   assign tick    = r_tick;
   assign clkOut  = r_clkout;
   assign irq     = r_irq;

endmodule
